// File: rtl/seq_pkg.sv
// Shared constants for the serial pattern transmitter and its sequence-detector partner.
package seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        GAP   = ST_GAP,
        DONE  = ST_DONE
    } state_t;

    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/pat_shreg.sv
// Pattern shift register: parallel load, shift left with zero fill, MSB tap for the serial output.
module pat_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first rep_cnt times with gap_len idle cycles between.
//
//  state | meaning
//  IDLE  | waiting for start; latches rep_cnt/gap_len and loads the pattern
//  SHIFT | pattern bit on out, frame high
//  GAP   | idle zeros between repetitions
//  DONE  | one-cycle done pulse, then back to IDLE
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int             PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int             REP_W   = 8,
    parameter int             GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             out,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

    state_t             state_q, state_d;
    logic [REP_W-1:0]   rep_left;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               load, shift, msb;

    pat_shreg #(.W(PAT_W)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .load_val (PATTERN),
        .msb      (msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        out     = 1'b0;
        frame   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    state_d = (rep_cnt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                out   = msb;
                frame = 1'b1;
                shift = 1'b1;
                if (bit_cnt == '0) begin
                    if (rep_left == REP_W'(1)) begin
                        state_d = DONE;
                    end else if (gap_q == '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transfer parameters are captured once so later input changes cannot disturb a running burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_left <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rep_left <= rep_cnt;
                        gap_q    <= gap_len;
                        bit_cnt  <= BIT_LAST;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        rep_left <= rep_left - REP_W'(1);
                        bit_cnt  <= BIT_LAST;
                        if (gap_q != '0) begin
                            gap_cnt <= gap_q - GAP_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt - BIT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: cycle-by-cycle comparison against a stream model built from the pattern rules.
module tb_seq_pattern_tx;

    localparam int         PAT_W   = 4;
    localparam logic [3:0] PATTERN = 4'b1011;
    localparam int         REP_W   = 8;
    localparam int         GAP_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [REP_W-1:0] rep_cnt = '0;
    logic [GAP_W-1:0] gap_len = '0;
    logic             out, frame, busy, done;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];   // {out, frame} per pattern/gap cycle
    logic [3:0] obs_q[$];   // {out, frame, busy, done} per observed cycle

    seq_pattern_tx #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .REP_W   (REP_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rep_cnt (rep_cnt),
        .gap_len (gap_len),
        .out     (out),
        .frame   (frame),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic void build_model(int rep, int gap);
        logic [PAT_W-1:0] pat;
        pat = PATTERN;
        exp_q.delete();
        for (int r = 0; r < rep; r++) begin
            for (int b = 0; b < PAT_W; b++) exp_q.push_back({pat[PAT_W-1-b], 1'b1});
            if (r < rep - 1) for (int g = 0; g < gap; g++) exp_q.push_back(2'b00);
        end
    endfunction

    function automatic logic [3:0] expected_at(int i);
        int n;
        n = exp_q.size();
        if (i < n)  return {exp_q[i], 1'b1, 1'b0};
        if (i == n) return 4'b0011;
        return 4'b0000;
    endfunction

    // Pulse start for one edge; returns at the negedge after the accepting edge.
    task automatic launch(int rep, int gap);
        @(negedge clk);
        start   = 1'b1;
        rep_cnt = REP_W'(rep);
        gap_len = GAP_W'(gap);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Record n cycles; during the first noise_n cycles scramble start/rep_cnt/gap_len.
    task automatic capture(int n, int noise_n);
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            obs_q.push_back({out, frame, busy, done});
            if (i < noise_n) begin
                start   = 1'($urandom_range(0, 1));
                rep_cnt = REP_W'($urandom);
                gap_len = GAP_W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({out, frame, busy, done} !== 4'b0000) begin
            bad++; $display("FAIL reset_initial: got %b want 0000", {out, frame, busy, done});
        end
        @(negedge clk);
        rst = 1'b1;
        launch(3, 2);
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL reset_prerun_busy: got %b want 1", busy);
        end
        start = 1'b1;
        #1 rst = 1'b0;
        #1;
        total++;
        if ({out, frame, busy, done} !== 4'b0000) begin
            bad++; $display("FAIL reset_async: got %b want 0000", {out, frame, busy, done});
        end
        @(negedge clk);
        total++;
        if ({out, frame, busy, done} !== 4'b0000) begin
            bad++; $display("FAIL reset_held: got %b want 0000", {out, frame, busy, done});
        end
        start = 1'b0;
        rst   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({out, frame, busy, done} !== 4'b0000) begin
                bad++; $display("FAIL reset_idle_after: got %b want 0000", {out, frame, busy, done});
            end
        end
    endtask

    task automatic test_single();
        build_model(1, 0);
        launch(1, 0);
        capture(exp_q.size() + 3, 0);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== expected_at(i)) begin
                bad++; $display("FAIL single cyc%0d: got %b want %b", i, obs_q[i], expected_at(i));
            end
        end
    endtask

    task automatic test_repeat_gap();
        int done_cyc;
        build_model(3, 2);
        launch(3, 2);
        capture(exp_q.size() + 3, 0);
        done_cyc = -1;
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== expected_at(i)) begin
                bad++; $display("FAIL repeat_gap cyc%0d: got %b want %b", i, obs_q[i], expected_at(i));
            end
            if (obs_q[i][0] && done_cyc < 0) done_cyc = i + 1;
        end
        total++;
        if (done_cyc !== 17) begin
            bad++; $display("FAIL repeat_gap_done_cycle: got %0d want 17", done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int frame_run;
        build_model(2, 0);
        launch(2, 0);
        capture(exp_q.size() + 3, 0);
        frame_run = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== expected_at(i)) begin
                bad++; $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs_q[i], expected_at(i));
            end
            if (obs_q[i][2] && frame_run == i) frame_run++;
        end
        total++;
        if (frame_run !== 8) begin
            bad++; $display("FAIL back_to_back_frame_run: got %0d want 8", frame_run);
        end
    endtask

    task automatic test_zero_ignore();
        build_model(0, 0);
        launch(0, 3);
        capture(4, 0);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== expected_at(i)) begin
                bad++; $display("FAIL zero_rep cyc%0d: got %b want %b", i, obs_q[i], expected_at(i));
            end
        end
        build_model(2, 1);
        launch(2, 1);
        capture(exp_q.size() + 3, exp_q.size() + 1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== expected_at(i)) begin
                bad++; $display("FAIL ignore_start cyc%0d: got %b want %b", i, obs_q[i], expected_at(i));
            end
        end
    endtask

    task automatic test_loopback();
        logic [3:0] win;
        int         hits;
        build_model(5, 1);
        launch(5, 1);
        capture(exp_q.size() + 3, 0);
        win  = '0;
        hits = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            win = {win[2:0], obs_q[i][3]};
            if (win == PATTERN) begin
                hits++;
                total++;
                if (obs_q[i][2] !== 1'b1) begin
                    bad++; $display("FAIL loopback_hit_in_gap cyc%0d: frame=%b want 1", i, obs_q[i][2]);
                end
            end
        end
        total++;
        if (hits !== 5) begin
            bad++; $display("FAIL loopback_hits: got %0d want 5", hits);
        end
    endtask

    task automatic test_random();
        int rep, gap;
        for (int t = 0; t < 10; t++) begin
            rep = $urandom_range(0, 6);
            gap = $urandom_range(0, 3);
            build_model(rep, gap);
            launch(rep, gap);
            capture(exp_q.size() + 3, exp_q.size() + 1);
            for (int i = 0; i < obs_q.size(); i++) begin
                total++;
                if (obs_q[i] !== expected_at(i)) begin
                    bad++;
                    $display("FAIL random rep=%0d gap=%0d cyc%0d: got %b want %b",
                             rep, gap, i, obs_q[i], expected_at(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_gap();
        test_back_to_back();
        test_zero_ignore();
        test_loopback();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
